// File: rtl/aw_channel_arbiter.sv
// Write-address arbiter/router for the 2x2 interconnect: round-robin between S00/S01,
// address decode to M00/M01, one registered request in flight, W-route sideband.
module aw_channel_arbiter #(
    parameter int                       Slaves_Num     = 2,
    parameter int                       Slaves_ID_Size = $clog2(Slaves_Num),
    parameter int                       Address_width  = 32,
    parameter int                       Len_width      = 8,
    parameter logic [Address_width-1:0] M01_Base_Addr  = 32'h8000_0000
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,

    input  logic [Address_width-1:0]  S00_AXI_awaddr,
    input  logic [Len_width-1:0]      S00_AXI_awlen,
    input  logic                      S00_AXI_awvalid,
    output logic                      S00_AXI_awready,

    input  logic [Address_width-1:0]  S01_AXI_awaddr,
    input  logic [Len_width-1:0]      S01_AXI_awlen,
    input  logic                      S01_AXI_awvalid,
    output logic                      S01_AXI_awready,

    output logic [Address_width-1:0]  M00_AXI_awaddr,
    output logic [Len_width-1:0]      M00_AXI_awlen,
    output logic                      M00_AXI_awvalid,
    input  logic                      M00_AXI_awready,

    output logic [Address_width-1:0]  M01_AXI_awaddr,
    output logic [Len_width-1:0]      M01_AXI_awlen,
    output logic                      M01_AXI_awvalid,
    input  logic                      M01_AXI_awready,

    input  logic                      Queue_Full_M00,
    input  logic                      Queue_Full_M01,

    output logic [Slaves_ID_Size-1:0] AW_Selected_Slave,
    output logic                      AW_Access_Grant,
    output logic [1:0]                Q_Enable_W_Data_In
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                      state;
    logic                        last_grant;
    logic [Address_width-1:0]    addr_q;
    logic [Len_width-1:0]        len_q;
    logic                        tgt_q;
    logic [Slaves_ID_Size-1:0]   sel_q;

    logic tgt_s00, tgt_s01;
    logic elig_s00, elig_s01;
    logic win_valid;
    logic winner;
    logic issue_ready;

    // Target decode: 1 selects M01, 0 selects M00.
    assign tgt_s00 = (S00_AXI_awaddr >= M01_Base_Addr);
    assign tgt_s01 = (S01_AXI_awaddr >= M01_Base_Addr);

    // A requester whose W-route queue is full stands aside without blocking the other.
    assign elig_s00 = S00_AXI_awvalid & ~(tgt_s00 ? Queue_Full_M01 : Queue_Full_M00);
    assign elig_s01 = S01_AXI_awvalid & ~(tgt_s01 ? Queue_Full_M01 : Queue_Full_M00);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        win_valid = 1'b0;
        winner    = 1'b0;
        if (state == IDLE) begin
            if (elig_s00 && elig_s01) begin
                win_valid = 1'b1;
                winner    = ~last_grant;
            end else if (elig_s00) begin
                win_valid = 1'b1;
                winner    = 1'b0;
            end else if (elig_s01) begin
                win_valid = 1'b1;
                winner    = 1'b1;
            end
        end
    end

    assign S00_AXI_awready = win_valid & ~winner;
    assign S01_AXI_awready = win_valid &  winner;

    assign issue_ready = tgt_q ? M01_AXI_awready : M00_AXI_awready;

    // Both ports carry the captured payload; only the selected port's valid is raised.
    assign M00_AXI_awaddr  = addr_q;
    assign M00_AXI_awlen   = len_q;
    assign M01_AXI_awaddr  = addr_q;
    assign M01_AXI_awlen   = len_q;
    assign M00_AXI_awvalid = (state == ISSUE) & ~tgt_q;
    assign M01_AXI_awvalid = (state == ISSUE) &  tgt_q;

    assign AW_Access_Grant    = (state == ISSUE) & issue_ready;
    assign Q_Enable_W_Data_In = AW_Access_Grant ? (tgt_q ? 2'b10 : 2'b01) : 2'b00;
    assign AW_Selected_Slave  = sel_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            addr_q     <= '0;
            len_q      <= '0;
            tgt_q      <= 1'b0;
            sel_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        addr_q     <= winner ? S01_AXI_awaddr : S00_AXI_awaddr;
                        len_q      <= winner ? S01_AXI_awlen  : S00_AXI_awlen;
                        tgt_q      <= winner ? tgt_s01        : tgt_s00;
                        sel_q      <= Slaves_ID_Size'(winner);
                        last_grant <= winner;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Payload is frozen here; queue-full changes cannot retract an issued request.
                    if (issue_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aw_channel_arbiter.md
Name: aw_channel_arbiter

Overview:
Write-address (AW) arbiter and router for the 2x2 interconnect. It arbitrates the S00/S01 AW requests round-robin and decodes each address to the M00 or M01 port. It registers the winning request and forwards it to that port. It also produces the AW_Selected_Slave, AW_Access_Grant and Q_Enable_W_Data_In sideband that the write-data channel controller uses to enqueue the write-data route.

Parameters:
Slaves_Num, 2, number of requesting AXI slave ports (fixed at 2 in this block)
Slaves_ID_Size, $clog2(Slaves_Num), width of the requester ID
Address_width, 32, AW address width
Len_width, 8, AWLEN width
M01_Base_Addr, 32'h8000_0000, addresses >= this go to M01; all lower addresses go to M00

Ports:
ACLK  in  1  clock, all state on rising edge
ARESETN  in  1  asynchronous active-low reset
S00_AXI_awaddr  in  Address_width  S00 write address
S00_AXI_awlen  in  Len_width  S00 burst length
S00_AXI_awvalid  in  1  S00 AW valid
S00_AXI_awready  out  1  S00 AW ready
S01_AXI_awaddr  in  Address_width  S01 write address
S01_AXI_awlen  in  Len_width  S01 burst length
S01_AXI_awvalid  in  1  S01 AW valid
S01_AXI_awready  out  1  S01 AW ready
M00_AXI_awaddr / M01_AXI_awaddr  out  Address_width  registered forwarded address
M00_AXI_awlen / M01_AXI_awlen  out  Len_width  registered forwarded length
M00_AXI_awvalid / M01_AXI_awvalid  out  1  forwarded valid
M00_AXI_awready / M01_AXI_awready  in  1  downstream ready
Queue_Full_M00  in  1  M00 write-data route queue full
Queue_Full_M01  in  1  M01 write-data route queue full
AW_Selected_Slave  out  Slaves_ID_Size  requester of the current transfer (0=S00, 1=S01)
AW_Access_Grant  out  1  one-cycle pulse when the downstream AW handshake completes
Q_Enable_W_Data_In  out  2  one-hot target port ([0]=M00, [1]=M01), valid with AW_Access_Grant

Behaviour:
- Clock and reset are fixed: one clock, ACLK; reset ARESETN, asynchronous, active-low.
- Reset state:
  - state=IDLE, last_grant=1 (S00 wins first tie).
  - All awvalid/awready outputs, AW_Access_Grant and Q_Enable_W_Data_In are 0.
  - Registered addr/len are 0; AW_Selected_Slave is 0.
- Decode, per requester: tgt = (awaddr >= M01_Base_Addr). Unsigned compare over the full Address_width.
- Eligibility: elig_i = Sxx_awvalid & ~Queue_Full[tgt_i].
  - A request whose target queue is full is not eligible.
  - That request does not block the other requester.
- State IDLE:
  - No eligible requester: stay in IDLE.
  - One eligible requester: it wins.
  - Both eligible: the winner is ~last_grant.
  - On a win, the winner's Sxx_awready=1 combinationally in that cycle. At the clock edge, capture addr/len/tgt/requester, set last_grant=winner, go to ISSUE.
  - The loser's awready stays 0.
- State ISSUE:
  - Mxx_awvalid=1 on port tgt only, with the registered addr/len; the other port's awvalid=0.
  - Both Sxx_awready=0.
  - Hold until Mxx_awready=1, then return to IDLE.
  - A new request is accepted no earlier than the cycle after the return, giving a throughput of 1 transfer per 2 cycles minimum.
- Sideband:
  - AW_Access_Grant = (state==ISSUE) & M[tgt]_awready, combinational.
  - Q_Enable_W_Data_In = onehot(tgt) when AW_Access_Grant=1, else 2'b00.
  - AW_Selected_Slave = captured requester; it holds its value outside ISSUE.
- Latency: S handshake in cycle N gives M awvalid in cycle N+1 and a grant pulse in the M handshake cycle, N+1 at best.
- Queue full is sampled only in IDLE. A full flag that asserts during ISSUE does not cancel the issued request.
- Registered addr/len/tgt are stable for the whole of ISSUE, and Mxx_awvalid never deasserts before awready (AXI rule).
- Reset mid-ISSUE: outputs clear asynchronously. The pending request is dropped with no grant pulse, and last_grant returns to 1.

Test Plan:
1. S00 awaddr=0x0000_1000, len=3, M00_awready=1 -> S00_awready pulses 1 cycle. Next cycle M00_awvalid=1 with addr 0x1000 and len 3. The same cycle shows AW_Access_Grant=1, Q_Enable=2'b01, AW_Selected_Slave=0.
2. S00 and S01 both valid continuously, addr 0x8000_0000 and 0x9000_0000 -> grants alternate S00, S01, S00... Every transfer goes to M01 with Q_Enable=2'b10.
3. Queue_Full_M00=1; S00 targets M00 and S01 targets M01 -> only S01 is served. Deassert the full flag -> S00 is served next.
4. M01_awready held 0 for 5 cycles -> M01_awvalid and addr stay stable for 5 cycles. No grant pulse until awready=1, and S awready stays 0 throughout.
5. Boundary decode: addr 0x7FFF_FFFF -> M00; addr 0x8000_0000 -> M01.
6. Assert ARESETN=0 during ISSUE -> M awvalid drops immediately with no grant pulse. After release, a tie is granted to S00 first.
